// File: rtl/prog_launcher.sv
`timescale 1ns/1ps
// prog_launcher: sequences a processor under test through NUM_PROGS programs.
// It pulses the processor reset once, then for each program strobes DutStart,
// waits one guard cycle and counts run cycles until DutAck or a timeout.
// Handshake: DutAck is a level sampled on every posedge Clk; it is only
// honoured in RUN and is ignored in every other state.
module prog_launcher #(
    parameter int          NUM_PROGS    = 3,
    parameter int          RST_CYCLES   = 2,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd10000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic        DutAck,
    output logic        DutReset,
    output logic        DutStart,
    output logic        Busy,
    output logic        Done,
    output logic        TimedOut,
    output logic [1:0]  ProgIdx,
    output logic [15:0] LastCount,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_GUARD = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] phase_cnt;  // cycles spent so far in RST or START
    logic [15:0] run_cnt;    // cycles since DutStart fell, excluding the current one
    logic        idle_rst;   // keep the processor in reset while IDLE (power-up or abort)
    logic        last_prog;
    logic        phase_hold;

    assign last_prog  = (ProgIdx == 2'(NUM_PROGS - 1));
    assign phase_hold = (state_nxt == state) && (state == S_RST || state == S_START);

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DutAck wins over the timeout check in RUN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Go) state_nxt = S_RST;
            S_RST:   if (phase_cnt == 16'(RST_CYCLES - 1)) state_nxt = S_START;
            S_START: if (phase_cnt == 16'(START_CYCLES - 1)) state_nxt = S_GUARD;
            S_GUARD: state_nxt = S_RUN;
            S_RUN: begin
                if (DutAck) begin
                    state_nxt = S_DONE;
                end else if (run_cnt == TIMEOUT) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE:  state_nxt = last_prog ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        DutReset  = (state == S_RST) || (state == S_IDLE && idle_rst);
        DutStart  = (state == S_START);
        Busy      = (state != S_IDLE);
        Done      = (state == S_DONE);
        dbg_state = state;
    end

    // Counters, program index, result and flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            phase_cnt <= '0;
            run_cnt   <= '0;
            LastCount <= '0;
            ProgIdx   <= '0;
            TimedOut  <= 1'b0;
            idle_rst  <= 1'b1;
        end else begin
            phase_cnt <= phase_hold ? phase_cnt + 16'd1 : '0;
            case (state)
                S_IDLE: begin
                    if (Go) begin
                        TimedOut <= 1'b0;
                        ProgIdx  <= '0;
                        idle_rst <= 1'b0;
                    end
                end
                S_START: run_cnt <= '0;
                // The guard cycle is the first DutStart-low cycle, so it counts as 1
                S_GUARD: run_cnt <= 16'd1;
                S_RUN: begin
                    if (DutAck) begin
                        LastCount <= run_cnt + 16'd1;
                    end else if (run_cnt == TIMEOUT) begin
                        TimedOut <= 1'b1;
                        idle_rst <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 16'd1;
                    end
                end
                S_DONE: ProgIdx <= last_prog ? 2'd0 : ProgIdx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_launcher.md
PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 The block SHALL have parameter NUM_PROGS, default 3, meaning the number of programs run back-to-back per Go.
REQ-002 The block SHALL have parameter RST_CYCLES, default 2, meaning the number of cycles DutReset is held high before the first program.
REQ-003 The block SHALL have parameter START_CYCLES, default 2, meaning the number of cycles DutStart is held high per program.
REQ-004 The block SHALL have parameter TIMEOUT, default 16'd10000, meaning the maximum number of run cycles allowed per program.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port Go, input, 1 bit: request to run the program sequence.
REQ-008 The block SHALL have port DutAck, input, 1 bit: done flag from the processor.
REQ-009 The block SHALL have port DutReset, output, 1 bit: active-high reset to the processor.
REQ-010 The block SHALL have port DutStart, output, 1 bit: start-next-program strobe to the processor.
REQ-011 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse per completed program.
REQ-013 The block SHALL have port TimedOut, output, 1 bit: sticky abort flag.
REQ-014 The block SHALL have port ProgIdx, output, 2 bits: index of the current or next program.
REQ-015 The block SHALL have port LastCount, output, 16 bits: cycle count of the most recently completed program.

Function
REQ-016 The FSM SHALL have states IDLE, RST, START, GUARD, RUN, DONE.
REQ-017 In IDLE, a Go sampled high SHALL clear TimedOut and ProgIdx and move the FSM to RST; Go SHALL be ignored in every other state.
REQ-018 RST SHALL drive DutReset=1 for exactly RST_CYCLES cycles and then move to START; DutReset SHALL be 0 in START, GUARD, RUN and DONE.
REQ-019 START SHALL drive DutStart=1 for exactly START_CYCLES cycles, clear RunCnt to 0, and then move to GUARD.
REQ-020 GUARD SHALL last exactly 1 cycle with DutStart=0, SHALL ignore DutAck, and SHALL set RunCnt to 1.
REQ-021 In RUN, DutAck sampled high SHALL load LastCount with RunCnt+1 and move the FSM to DONE.
REQ-022 In RUN, DutAck sampled low SHALL increment RunCnt.
REQ-023 LastCount SHALL equal the number of cycles from the first DutStart-low cycle through the DutAck-high cycle, inclusive.
REQ-024 In RUN, if RunCnt reaches TIMEOUT with DutAck low, the block SHALL set TimedOut=1, drive DutReset=1, and return to IDLE without pulsing Done; this check SHALL have priority below DutAck sampled high in the same cycle.
REQ-025 DONE SHALL last 1 cycle with Done=1 and SHALL increment ProgIdx.
REQ-026 From DONE, if the completed program was index NUM_PROGS-1, the FSM SHALL move to IDLE with ProgIdx=0; otherwise it SHALL move to START with no DUT reset between programs.
REQ-027 RunCnt SHALL be 16 bits and SHALL never wrap; TIMEOUT bounds it.
REQ-028 In IDLE after a completed sequence, DutReset SHALL stay 0 and LastCount SHALL hold its value.
REQ-029 In IDLE after a timeout, DutReset SHALL stay 1 until the next Go.

Reset
REQ-030 Reset low SHALL immediately, at any state or cycle, force the FSM to IDLE and drive DutReset=1, DutStart=0, Busy=0, Done=0, TimedOut=0, ProgIdx=0, LastCount=0 and RunCnt=0.
REQ-031 Reset low mid-run SHALL abort the run without a Done pulse.

Verification
REQ-032 A bench SHALL cover: Go pulse, DUT raises DutAck on the 5th cycle after DutStart falls, for each of 3 programs -> 3 Done pulses, LastCount=5 each time, ProgIdx sequence 0,1,2,0, DutReset high only for the first 2 cycles.
REQ-033 A bench SHALL cover: DutAck held high throughout START and GUARD, then low for 3 cycles, then high -> Ack ignored until RUN, LastCount=5.
REQ-034 A bench SHALL cover: TIMEOUT=8 with DutAck never high -> TimedOut=1 after the 8th run cycle, no Done pulse, DutReset=1, Busy=0.
REQ-035 A bench SHALL cover: DutAck rising on the same cycle RunCnt reaches TIMEOUT -> DONE taken, TimedOut=0.
REQ-036 A bench SHALL cover: Go re-pulsed during RUN -> no effect on state, ProgIdx or counts.
REQ-037 A bench SHALL cover: Reset driven low for 1 cycle during RUN of program 1 -> all outputs at reset values asynchronously, no Done pulse, and a subsequent Go restarts at ProgIdx=0.
